// File: rtl/midi_decoder_if.sv
// MIDI decoder byte-in / message-out bundle and command code package.
// The UART side drives rx_*; the decoder drives midi_*.
package midi_pkg;
  localparam int MIDI_CMD_SIZE = 3;
  typedef logic [MIDI_CMD_SIZE-1:0] midi_cmd_t;
  localparam midi_cmd_t MIDI_CMD_NONE       = 3'd0;
  localparam midi_cmd_t MIDI_CMD_NOTE_OFF   = 3'd1;
  localparam midi_cmd_t MIDI_CMD_NOTE_ON    = 3'd2;
  localparam midi_cmd_t MIDI_CMD_POLY_AT    = 3'd3;
  localparam midi_cmd_t MIDI_CMD_CC         = 3'd4;
  localparam midi_cmd_t MIDI_CMD_PROG_CHG   = 3'd5;
  localparam midi_cmd_t MIDI_CMD_CH_AT      = 3'd6;
  localparam midi_cmd_t MIDI_CMD_PITCH_BEND = 3'd7;
endpackage

interface midi_if;
  import midi_pkg::*;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       midi_rdy;
  midi_cmd_t  midi_cmd;
  logic [3:0] midi_ch_sysn;
  logic [6:0] midi_data0;
  logic [6:0] midi_data1;

  modport master (
    output rx_rdy, rx_data,
    input  midi_rdy, midi_cmd, midi_ch_sysn,
    input  midi_data0, midi_data1
  );

  modport slave (
    input  rx_rdy, rx_data,
    output midi_rdy, midi_cmd, midi_ch_sysn,
    output midi_data0, midi_data1
  );
endinterface

// File: rtl/midi_decoder.sv
// MIDI byte parser: running status, 1/2 data-byte channel messages,
// system common aborts, real-time bytes transparent.
module midi_decoder
  import midi_pkg::*;
#(
  parameter bit VEL0_IS_NOTE_OFF = 1'b1
) (
  input  logic    clk,
  input  logic    reset,
  midi_if.slave   bus
);

  typedef enum logic [1:0] {
    NO_STATUS,
    WAIT_D0,
    WAIT_D1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] run_status_q, run_status_d;
  logic       run_vld_q, run_vld_d;
  logic [6:0] d0_q, d0_d;
  logic       rdy_q, rdy_d;
  midi_cmd_t  cmd_q, cmd_d;
  logic [3:0] ch_q, ch_d;
  logic [6:0] data0_q, data0_d;
  logic [6:0] data1_q, data1_d;

  logic       is_chan, is_sysc, is_rt;
  logic       one_byte;
  logic [3:0] nib;
  midi_cmd_t  base_cmd;
  logic       ev;
  logic [6:0] ev_d0, ev_d1;

  always_comb begin
    state_d      = state_q;
    run_status_d = run_status_q;
    run_vld_d    = run_vld_q;
    d0_d         = d0_q;
    rdy_d        = 1'b0;
    cmd_d        = cmd_q;
    ch_d         = ch_q;
    data0_d      = data0_q;
    data1_d      = data1_q;
    ev           = 1'b0;
    ev_d0        = 7'd0;
    ev_d1        = 7'd0;

    is_chan  = bus.rx_data[7] && (bus.rx_data[7:4] != 4'hF);
    is_sysc  = bus.rx_data[7:3] == 5'b11110;
    is_rt    = bus.rx_data[7:3] == 5'b11111;
    nib      = run_status_q[7:4];
    one_byte = (nib == 4'hC) || (nib == 4'hD);
    base_cmd = midi_cmd_t'(nib[2:0] + 3'd1);

    if (bus.rx_rdy) begin
      unique case (1'b1)
        is_chan: begin
          run_status_d = bus.rx_data;
          run_vld_d    = 1'b1;
          state_d      = WAIT_D0;
        end
        is_sysc: begin
          run_vld_d = 1'b0;
          state_d   = NO_STATUS;
        end
        is_rt: ;
        default: begin
          if (run_vld_q) begin
            case (state_q)
              WAIT_D0: begin
                d0_d = bus.rx_data[6:0];
                if (one_byte) begin
                  ev    = 1'b1;
                  ev_d0 = bus.rx_data[6:0];
                end else begin
                  state_d = WAIT_D1;
                end
              end
              WAIT_D1: begin
                ev      = 1'b1;
                ev_d0   = d0_q;
                ev_d1   = bus.rx_data[6:0];
                state_d = WAIT_D0;
              end
              default: ;
            endcase
          end
        end
      endcase
    end

    if (ev) begin
      rdy_d   = 1'b1;
      cmd_d   = base_cmd;
      if (VEL0_IS_NOTE_OFF && base_cmd == MIDI_CMD_NOTE_ON
          && ev_d1 == 7'd0)
        cmd_d = MIDI_CMD_NOTE_OFF;
      ch_d    = run_status_q[3:0];
      data0_d = ev_d0;
      data1_d = ev_d1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= NO_STATUS;
      run_status_q <= 8'd0;
      run_vld_q    <= 1'b0;
      d0_q         <= 7'd0;
      rdy_q        <= 1'b0;
      cmd_q        <= MIDI_CMD_NONE;
      ch_q         <= 4'd0;
      data0_q      <= 7'd0;
      data1_q      <= 7'd0;
    end else begin
      state_q      <= state_d;
      run_status_q <= run_status_d;
      run_vld_q    <= run_vld_d;
      d0_q         <= d0_d;
      rdy_q        <= rdy_d;
      cmd_q        <= cmd_d;
      ch_q         <= ch_d;
      data0_q      <= data0_d;
      data1_q      <= data1_d;
    end
  end

  assign bus.midi_rdy     = rdy_q;
  assign bus.midi_cmd     = cmd_q;
  assign bus.midi_ch_sysn = ch_q;
  assign bus.midi_data0   = data0_q;
  assign bus.midi_data1   = data1_q;

endmodule
